// File: rtl/utils_pkg.sv
// Shared LSU/bus types plus the write-back load alignment helper.
package utils_pkg;

  typedef enum logic [1:0] {
    CB_OKAY   = 2'd0,
    CB_EXOKAY = 2'd1,
    CB_SLVERR = 2'd2,
    CB_DECERR = 2'd3
  } cb_resp_t;

  typedef enum logic [1:0] {
    LSU_NONE  = 2'd0,
    LSU_LOAD  = 2'd1,
    LSU_STORE = 2'd2,
    LSU_AMO   = 2'd3
  } lsu_op_typ_t;

  typedef enum logic [2:0] {
    RV_LSU_B  = 3'd0,
    RV_LSU_H  = 3'd1,
    RV_LSU_W  = 3'd2,
    RV_LSU_BU = 3'd4,
    RV_LSU_HU = 3'd5
  } lsu_width_t;

  typedef struct packed {
    lsu_op_typ_t op_typ;
    lsu_width_t  width;
    logic [31:0] addr;
    logic [4:0]  rd_addr;
  } s_lsu_op_t;

  localparam int unsigned ST_MAX_OUT_STORES = 4;
  localparam int unsigned ST_CNT_W          = $clog2(ST_MAX_OUT_STORES) + 1;

  // Select the addressed byte/halfword lane of a word-aligned beat and extend it.
  function automatic logic [31:0] lsu_wb_align(input lsu_width_t  width,
                                               input logic [1:0]  addr,
                                               input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b   = 8'h00;
    h   = addr[1] ? rdata[31:16] : rdata[15:0];
    res = rdata;
    case (addr)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    case (width)
      RV_LSU_B:  res = {{24{b[7]}}, b};
      RV_LSU_BU: res = {24'h000000, b};
      RV_LSU_H:  res = {{16{h[15]}}, h};
      RV_LSU_HU: res = {16'h0000, h};
      default:   res = rdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_wb_st_fifo.sv
// Store-address FIFO: head is combinational, count and full/busy flags are registered.
module lsu_st_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_c_o,
  output logic                         full_o,
  output logic                         busy_o,
  output logic [$clog2(DEPTH):0]       cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, busy_q;
  logic             do_push, do_pop;

  // A pop frees a slot in the same cycle, so push is accepted when full only alongside a pop.
  always_comb begin
    do_pop  = pop_i && (cnt_q != '0);
    do_push = push_i && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
    cnt_d   = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == CNT_W'(DEPTH));
      busy_q <= (cnt_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push_i && !do_push))
        else $error("lsu_st_fifo: push while full without pop was dropped");
    end
  end
`endif

  assign head_c_o = mem_q[rd_ptr_q];
  assign full_o   = full_q;
  assign busy_o   = busy_q;
  assign cnt_o    = cnt_q;

endmodule

// File: rtl/lsu_wb.sv
// LSU write-back: aligned register-file write, load faults, and outstanding-store tracking.
module lsu_wb
  import utils_pkg::*;
#(
  parameter int unsigned MAX_OUT_STORES  = ST_MAX_OUT_STORES,
  parameter bit          SUPPORT_WR_RESP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  s_lsu_op_t   lsu_op_i,
  input  logic [31:0] lsu_rdata_i,
  input  logic        rd_valid_i,
  input  cb_resp_t    rd_resp_i,
  input  logic        wr_data_valid_i,
  input  logic        wr_data_ready_i,
  input  logic        wr_resp_valid_i,
  input  cb_resp_t    wr_resp_error_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        ld_fault_o,
  output logic [31:0] ld_fault_addr_o,
  output logic        st_fault_o,
  output logic [31:0] st_fault_addr_o,
  output logic        st_full_o,
  output logic        st_busy_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUT_STORES) + 1;

  logic        ld_evt, ld_ok, ld_err, rf_we_d;
  logic        rf_we_q, ld_fault_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q, ld_fault_addr_q;

  always_comb begin
    ld_evt  = rd_valid_i && (lsu_op_i.op_typ == LSU_LOAD);
    ld_ok   = ld_evt && (rd_resp_i == CB_OKAY);
    ld_err  = ld_evt && (rd_resp_i != CB_OKAY);
    rf_we_d = ld_ok && (lsu_op_i.rd_addr != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q         <= 1'b0;
      rf_waddr_q      <= '0;
      rf_wdata_q      <= '0;
      ld_fault_q      <= 1'b0;
      ld_fault_addr_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      ld_fault_q <= ld_err;
      if (rf_we_d) begin
        rf_waddr_q <= lsu_op_i.rd_addr;
        rf_wdata_q <= lsu_wb_align(lsu_op_i.width, lsu_op_i.addr[1:0], lsu_rdata_i);
      end
      if (ld_err) ld_fault_addr_q <= lsu_op_i.addr;
    end
  end

  assign rf_we_o         = rf_we_q;
  assign rf_waddr_o      = rf_waddr_q;
  assign rf_wdata_o      = rf_wdata_q;
  assign ld_fault_o      = ld_fault_q;
  assign ld_fault_addr_o = ld_fault_addr_q;

  if (SUPPORT_WR_RESP) begin : g_st
    logic [31:0]      head;
    logic             full, busy, st_err;
    logic [CNT_W-1:0] cnt;
    logic             st_fault_q;
    logic [31:0]      st_fault_addr_q;

    lsu_st_fifo #(
      .DEPTH (MAX_OUT_STORES),
      .WIDTH (32)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_i   (wr_data_valid_i && wr_data_ready_i),
      .wdata_i  (lsu_op_i.addr),
      .pop_i    (wr_resp_valid_i),
      .head_c_o (head),
      .full_o   (full),
      .busy_o   (busy),
      .cnt_o    (cnt)
    );

    // Spurious responses (nothing outstanding) never fault.
    assign st_err = wr_resp_valid_i && (cnt != '0) && (wr_resp_error_i != CB_OKAY);

    always_ff @(posedge clk) begin
      if (rst) begin
        st_fault_q      <= 1'b0;
        st_fault_addr_q <= '0;
      end else begin
        st_fault_q <= st_err;
        if (st_err) st_fault_addr_q <= head;
      end
    end

    assign st_fault_o      = st_fault_q;
    assign st_fault_addr_o = st_fault_addr_q;
    assign st_full_o       = full;
    assign st_busy_o       = busy;
  end else begin : g_no_st
    assign st_fault_o      = 1'b0;
    assign st_fault_addr_o = '0;
    assign st_full_o       = 1'b0;
    assign st_busy_o       = 1'b0;
  end

endmodule

// File: doc/lsu_wb.md
Name: lsu_wb

Overview:
- Write-back side consumer of the load/store unit.
- Aligns and sign/zero-extends returned load data, then drives a registered register-file write port.
- Tracks in-flight stores until their write responses return, capturing the faulting address for load and store access faults.
- Exposes a store-drain indication so fence and trap logic can wait for outstanding stores.

Parameters:
- MAX_OUT_STORES, 4, maximum stores issued but not yet responded; power of two, 2..16.
- SUPPORT_WR_RESP, 1, 1 = track write responses; 0 = store tracking disabled, counter held at 0, no store faults.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- lsu_op_i  in  s_lsu_op_t  op currently in the LSU data phase; uses op_typ, width, addr, rd_addr
- lsu_rdata_i  in  32  raw bus read data, word-aligned
- rd_valid_i  in  1  read data beat valid; ready is always 1
- rd_resp_i  in  cb_resp_t  read response code
- wr_data_valid_i  in  1  store data beat valid
- wr_data_ready_i  in  1  store data beat accepted
- wr_resp_valid_i  in  1  write response valid; ready is always 1
- wr_resp_error_i  in  cb_resp_t  write response code
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  5  destination register
- rf_wdata_o  out  32  aligned and extended load value
- ld_fault_o  out  1  load access fault pulse
- ld_fault_addr_o  out  32  byte address of the faulting load
- st_fault_o  out  1  store access fault pulse
- st_fault_addr_o  out  32  byte address of the faulting store
- st_full_o  out  1  outstanding stores == MAX_OUT_STORES; upstream must not issue a store
- st_busy_o  out  1  outstanding stores != 0

Behaviour:
- Reset: every output is 0, the outstanding count is 0, and the address FIFO is empty. Reset during operation discards pending state; responses arriving after reset count as spurious.
- Load completion:
  - Occurs on cycle N when rd_valid_i=1 and lsu_op_i.op_typ==LSU_LOAD.
  - If rd_resp_i==CB_OKAY, then in N+1: rf_we_o=1 for exactly one cycle, rf_waddr_o=lsu_op_i.rd_addr, rf_wdata_o=aligned value.
  - If rd_addr==0, rf_we_o stays 0.
- Alignment:
  - Byte lane k = addr[1:0].
  - Halfword lane = addr[1]; addr[0] is ignored.
  - Word ignores addr[1:0].
  - RV_LSU_B and RV_LSU_H sign-extend; RV_LSU_BU and RV_LSU_HU zero-extend.
  - Any other width passes the word through unchanged.
- Load fault:
  - Triggered when rd_valid_i=1 and rd_resp_i!=CB_OKAY.
  - No register-file write.
  - In N+1: ld_fault_o=1 for one cycle; ld_fault_addr_o=lsu_op_i.addr, held until the next load fault.
- rd_valid_i while op_typ!=LSU_LOAD is ignored.
- Store issue: on a wr_data_valid_i && wr_data_ready_i handshake, push lsu_op_i.addr into the FIFO and increment the count.
- Store response: when wr_resp_valid_i=1, pop the FIFO and decrement the count.
- Simultaneous push and pop in one cycle: count unchanged, FIFO head advances, new entry is appended.
- Store fault:
  - Triggered when the popped response has wr_resp_error_i!=CB_OKAY.
  - Next cycle: st_fault_o=1 for one cycle; st_fault_addr_o=popped head address, held.
- Response with count==0 (spurious): ignored, count stays 0, no fault.
- Push while count==MAX_OUT_STORES (protocol violation): dropped, count saturates; this is a simulation-only assertion.
- st_full_o and st_busy_o are registered from the count, so they reflect the count after the previous edge.
- Load and store faults in the same cycle: both pulses assert, each with its own address port.
- Pointers are log2(MAX_OUT_STORES) bits and wrap naturally.
- The count is log2(MAX_OUT_STORES)+1 bits wide.

Decomposition:
- Extend utils_pkg with:
  - lsu_wb_align function (width, addr[1:0], rdata) -> 32-bit value
  - localparam ST_CNT_W
- Sub-module lsu_st_fifo:
  - Parameterised depth/width synchronous FIFO for store addresses.
  - Push/pop, full/empty, registered count; simultaneous push+pop allowed when full.
- lsu_wb instantiates lsu_st_fifo only when SUPPORT_WR_RESP=1.

Test Plan:
- LB addr 0x1003, rdata 0x80FF_1234, rd_addr=5, OKAY -> next cycle rf_we_o=1, waddr 5, wdata 0xFFFF_FF80.
- LHU addr 0x2002, rdata 0x8001_7F00 -> wdata 0x0000_8001. LW to rd_addr=0 -> rf_we_o stays 0.
- Load fault: rd_valid with SLVERR at addr 0x3004 -> ld_fault_o pulse, ld_fault_addr_o=0x3004, no rf write.
- Four stores to 0x100, 0x104, 0x108, 0x10C with no responses -> st_full_o=1. Responses OKAY, OKAY, SLVERR, OKAY -> st_fault_o once with st_fault_addr_o=0x108; st_busy_o=0 after the last response.
- Store push and response in the same cycle at count 2 -> count stays 2, FIFO order preserved. Spurious response at count 0 -> no fault, count stays 0.
- Assert rst with 3 stores outstanding -> all outputs 0 the next cycle, a later response is ignored, and no fault is reported.
